// File: rtl/mult_pkg.sv
// Shared widths, step limit and FSM state type for the add-shift multiplier.
// Build option MULT_SIGNED_EN selects two's-complement operand extension.
package mult_pkg;
  localparam int N_BITS = 8;
  localparam logic [2:0] LAST_STEP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ADD,
    S_SHIFT,
    S_DONE
  } mult_state_t;

  function automatic logic [N_BITS:0] ext_op(input logic [N_BITS-1:0] v);
`ifdef MULT_SIGNED_EN
    return {v[N_BITS-1], v};
`else
    return {1'b0, v};
`endif
  endfunction
endpackage

// File: rtl/mult_sequencer_reg_unit.sv
// X:A:B product register: clear X/A, load B, load X:A from the adder, right shift.
// MULT_SIGNED_EN keeps X on shift (sign); otherwise X is a carry cleared by the shift.
module reg_unit
  import mult_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_xa_i,
  input  logic              ld_b_i,
  input  logic              ld_xa_i,
  input  logic              shift_i,
  input  logic [N_BITS-1:0] b_dat_i,
  input  logic [N_BITS:0]   xa_dat_i,
  output logic              x_o,
  output logic [N_BITS-1:0] a_o,
  output logic [N_BITS-1:0] b_o
);
  logic              x_q, x_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    if (clr_xa_i) begin
      x_d = 1'b0;
      a_d = '0;
    end else if (ld_xa_i) begin
      {x_d, a_d} = xa_dat_i;
    end else if (shift_i) begin
      a_d = {x_q, a_q[N_BITS-1:1]};
      b_d = {a_q[0], b_q[N_BITS-1:1]};
`ifndef MULT_SIGNED_EN
      // the carry has now moved into A, so X must not feed the next shift
      x_d = 1'b0;
`endif
    end
    if (ld_b_i) b_d = b_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign x_o = x_q;
  assign a_o = a_q;
  assign b_o = b_q;
endmodule

// File: rtl/mult_sequencer.sv
// Add-shift sequencer for the 8-bit multiplier: 18 edges from Run to product in A:B.
// MULT_SIGNED_EN: two's-complement operands, last step subtracts.
module mult_sequencer
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              ClearA_LoadB,
  input  logic [N_BITS-1:0] Switches,
  input  logic [N_BITS:0]   Sum,
  output logic [N_BITS:0]   AddA,
  output logic [N_BITS:0]   AddB,
  output logic              ADD,
  output logic              SUB,
  output logic              M,
  output logic [N_BITS-1:0] Aval,
  output logic [N_BITS-1:0] Bval,
  output logic              Xval,
  output logic              Busy
);
  mult_state_t state_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        clr_xa, ld_b, ld_xa, shift, last_step;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!ClearA_LoadB && Run) begin
            state_q <= S_CLR;
            busy_q  <= 1'b1;
          end
        end
        S_CLR: begin
          cnt_q   <= '0;
          state_q <= S_ADD;
        end
        S_ADD: state_q <= S_SHIFT;
        S_SHIFT: begin
          if (cnt_q == LAST_STEP) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            state_q <= S_ADD;
          end
        end
        S_DONE: if (!Run) state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign last_step = (state_q == S_ADD) && (cnt_q == LAST_STEP);
  assign ld_b      = (state_q == S_IDLE) && ClearA_LoadB;
  assign clr_xa    = ld_b || (state_q == S_CLR);
  assign ld_xa     = (state_q == S_ADD) && M;
  assign shift     = (state_q == S_SHIFT);

`ifdef MULT_SIGNED_EN
  // multiplier bit 7 carries negative weight, so the final partial product is subtracted
  assign ADD = (state_q == S_ADD) && !last_step;
  assign SUB = last_step;
`else
  assign ADD = (state_q == S_ADD);
  assign SUB = 1'b0;
`endif

  reg_unit u_reg (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .clr_xa_i (clr_xa),
    .ld_b_i   (ld_b),
    .ld_xa_i  (ld_xa),
    .shift_i  (shift),
    .b_dat_i  (Switches),
    .xa_dat_i (Sum),
    .x_o      (Xval),
    .a_o      (Aval),
    .b_o      (Bval)
  );

  assign M    = Bval[0];
  assign AddA = ext_op(Aval);
  assign AddB = ext_op(Switches);
  assign Busy = busy_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a product-level reference model and an adder model.
module tb_mult_sequencer;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic [7:0] Switches = 8'h00;
  logic [8:0] Sum, AddA, AddB;
  logic       ADD, SUB, M, Xval, Busy;
  logic [7:0] Aval, Bval;

`ifdef MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  mult_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Switches(Switches), .Sum(Sum), .AddA(AddA), .AddB(AddB),
    .ADD(ADD), .SUB(SUB), .M(M), .Aval(Aval), .Bval(Bval),
    .Xval(Xval), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // external 9-bit adder/subtractor
  always_comb Sum = SUB ? (AddA - AddB) : (AddA + AddB);

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [8:0] ext9(input logic [7:0] v);
    return SGN ? {v[7], v} : {1'b0, v};
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] b, input logic [7:0] s);
    int x, y;
    if (SGN) begin
      x = $signed(b);
      y = $signed(s);
    end else begin
      x = int'(b);
      y = int'(s);
    end
    return 16'(x * y);
  endfunction

  // reference model: 0 idle, 1 running, 2 done; m_e counts edges since Run accepted
  int         m_mode = 0;
  int         m_e = 0;
  logic [7:0] mA = 8'h00, mB = 8'h00, m_mult = 8'h00, m_s = 8'h00;
  logic       mX = 1'b0;
  logic [15:0] m_p;

  assign m_p = prod(m_mult, m_s);

  always @(posedge Clk) begin
    if (Reset) begin
      m_mode <= 0; m_e <= 0; mA <= 8'h00; mB <= 8'h00; mX <= 1'b0;
    end else begin
      case (m_mode)
        0: begin
          if (ClearA_LoadB) begin
            mA <= 8'h00; mX <= 1'b0; mB <= Switches;
          end else if (Run) begin
            m_mode <= 1; m_e <= 1; m_mult <= mB; m_s <= Switches;
          end
        end
        1: begin
          if (m_e == 17) begin
            m_mode <= 2;
            {mA, mB} <= m_p;
            mX <= SGN & m_p[15];
          end else m_e <= m_e + 1;
        end
        default: if (!Run) m_mode <= 0;
      endcase
    end
  end

  // per-cycle compare against the model
  always @(negedge Clk) begin
    bit in_add;
    in_add = (m_mode == 1) && (m_e % 2 == 0) && (m_e >= 2) && (m_e <= 16);
    chk("busy", int'(Busy), int'(m_mode == 1));
    chk("add", int'(ADD), int'(in_add && !(SGN && m_e == 16)));
    chk("sub", int'(SUB), int'(in_add && SGN && m_e == 16));
    chk("addb", int'(AddB), int'(ext9(Switches)));
    if (m_mode != 1) begin
      chk("aval", int'(Aval), int'(mA));
      chk("bval", int'(Bval), int'(mB));
      chk("xval", int'(Xval), int'(mX));
      chk("m", int'(M), int'(mB[0]));
      chk("adda", int'(AddA), int'(ext9(mA)));
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic load_b(input logic [7:0] v);
    ClearA_LoadB = 1'b1;
    Switches = v;
    step();
    ClearA_LoadB = 1'b0;
  endtask

  task automatic do_run(input logic [7:0] s, input bit hold,
                        output int lat, output int nadd, output int nsub);
    Switches = s;
    Run = 1'b1;
    lat = 0; nadd = 0; nsub = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (n == 1 && !hold) Run = 1'b0;
      nadd += int'(ADD);
      nsub += int'(SUB);
      if (n > 1 && !Busy) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("run_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, na, ns;
    logic [15:0] e_t2, e_t3, e_t4;
    e_t2 = SGN ? 16'hFE63 : 16'h3963;
    e_t3 = SGN ? 16'h0001 : 16'hFE01;
    e_t4 = SGN ? 16'hFF3A : 16'h013A;

    step(); step();
    @(negedge Clk);
    chk("rst_a", int'(Aval), 0);
    chk("rst_b", int'(Bval), 0);
    chk("rst_x", int'(Xval), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_add", int'(ADD), 0);
    chk("rst_sub", int'(SUB), 0);
    chk("rst_adda", int'(AddA), 0);
    Reset = 1'b0;
    step();

    // 7 x 59 = 413
    load_b(8'h07);
    do_run(8'h3B, 1'b0, lat, na, ns);
    chk("t1_latency", lat, 18);
    chk("t1_prod", int'({Aval, Bval}), 16'h019D);
    chk("t1_x", int'(Xval), 0);
    chk("t1_busy", int'(Busy), 0);
    chk("t1_add_cycles", na, SGN ? 7 : 8);
    chk("t1_sub_cycles", ns, SGN ? 1 : 0);
    step();

    // -7 x 59 signed, 249 x 59 unsigned
    load_b(8'hF9);
    do_run(8'h3B, 1'b0, lat, na, ns);
    chk("t2_prod", int'({Aval, Bval}), int'(e_t2));
    chk("t2_x", int'(Xval), int'(SGN));
    chk("t2_sub_cycles", ns, SGN ? 1 : 0);
    step();

    load_b(8'hFF);
    do_run(8'hFF, 1'b0, lat, na, ns);
    chk("t3_prod", int'({Aval, Bval}), int'(e_t3));
    step();

    // Run held through DONE, ClearA_LoadB pulsed in DONE, then re-run on low byte 0x9D
    load_b(8'h07);
    do_run(8'h3B, 1'b1, lat, na, ns);
    for (int i = 0; i < 10; i++) begin
      ClearA_LoadB = (i == 4);
      Switches = (i == 4) ? 8'hAA : 8'h3B;
      step();
    end
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk("t4_hold_busy", int'(Busy), 0);
    chk("t4_hold_prod", int'({Aval, Bval}), 16'h019D);
    Run = 1'b0;
    Switches = 8'h02;
    step(); step();
    do_run(8'h02, 1'b0, lat, na, ns);
    chk("t4_rerun_prod", int'({Aval, Bval}), int'(e_t4));
    step();

    // reset mid-operation
    load_b(8'h07);
    Switches = 8'h3B;
    Run = 1'b1;
    repeat (5) step();
    Run = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge Clk);
    chk("t5_busy", int'(Busy), 0);
    chk("t5_a", int'(Aval), 0);
    chk("t5_b", int'(Bval), 0);
    chk("t5_x", int'(Xval), 0);
    chk("t5_add", int'(ADD), 0);
    chk("t5_sub", int'(SUB), 0);
    step();

    // ClearA_LoadB wins over Run in IDLE
    Switches = 8'h55;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    step();
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk("t6_b", int'(Bval), 8'h55);
    chk("t6_a", int'(Aval), 0);
    chk("t6_busy", int'(Busy), 0);
    step();
    @(negedge Clk);
    chk("t6_idle", int'(Busy), 0);
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
